// File: rtl/mem_stage.sv
// Memory-access stage: owns the EX->MEM register, completes data-RAM loads and drains cancelled responses.
// Optional MEM_LOAD_FWD_EN forwards load data to the bypass network in the cycle data_ok arrives.
module mem_stage #(
  parameter int DISCARD_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_ready_go,
  input  logic        ex_wait_data_ok,
  input  logic [4:0]  ex_ld_ctrl,
  input  logic [31:0] ex_result,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_rf_waddr,
  input  logic        ex_res_from_mem,
  input  logic [31:0] ex_pc,
  output logic        mem_allow_in,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        wb_allow_in,
  input  logic        wb_flush,
  output logic        mem_to_wb_valid,
  output logic [31:0] mem_final_result,
  output logic        mem_rf_we,
  output logic [4:0]  mem_rf_waddr,
  output logic [31:0] mem_pc,
  output logic        mem_bypass_we,
  output logic [4:0]  mem_bypass_waddr,
  output logic        mem_bypass_busy,
  output logic [31:0] mem_bypass_data
);

  localparam logic [DISCARD_W-1:0] DISCARD_MAX = '1;
  localparam logic [DISCARD_W-1:0] DISCARD_ONE = DISCARD_W'(1);

  logic                 vld_p1;
  logic                 wait_ok_p1;
  logic [4:0]           ld_ctrl_p1;
  logic [31:0]          result_p1;
  logic                 rf_we_p1;
  logic [4:0]           rf_waddr_p1;
  logic                 res_from_mem_p1;
  logic [31:0]          pc_p1;
  logic [31:0]          data_buf_p1;
  logic                 buf_valid_p1;
  logic [DISCARD_W-1:0] discard_cnt;

  logic        discarding;
  logic        data_ok_eff;
  logic        mem_ready_go;
  logic        handoff;
  logic        load_in;
  logic        discard_inc;
  logic        discard_dec;
  logic        buf_latch;
  logic [31:0] ld_raw;

  function automatic logic [31:0] load_extract(input logic [4:0] ld, input logic [1:0] addr,
                                               input logic [31:0] r, input logic [31:0] res);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = r[{addr, 3'b000} +: 8];
    h = addr[1] ? r[31:16] : r[15:0];
    if (ld[4])      return r;
    else if (ld[3]) return {24'b0, b};
    else if (ld[2]) return {{24{b[7]}}, b};
    else if (ld[1]) return {16'b0, h};
    else if (ld[0]) return {{16{h[15]}}, h};
    else            return res;
  endfunction

  // Responses owed to flushed instructions are swallowed before they can complete anything.
  assign discarding   = (discard_cnt != '0);
  assign data_ok_eff  = data_sram_data_ok & ~discarding;
  assign discard_dec  = data_sram_data_ok & discarding;
  assign mem_ready_go = ~wait_ok_p1 | buf_valid_p1 | data_ok_eff;
  assign mem_allow_in = (~vld_p1 | (mem_ready_go & wb_allow_in)) & ~(discarding & ex_wait_data_ok);
  assign handoff      = vld_p1 & mem_ready_go & wb_allow_in & ~wb_flush;
  assign load_in      = ex_valid & ex_ready_go & mem_allow_in;
  assign discard_inc  = wb_flush & vld_p1 & wait_ok_p1 & ~buf_valid_p1 & ~data_ok_eff;
  assign buf_latch    = vld_p1 & wait_ok_p1 & ~buf_valid_p1 & data_ok_eff & ~wb_allow_in;

  // EX -> MEM boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1          <= 1'b0;
      wait_ok_p1      <= 1'b0;
      ld_ctrl_p1      <= '0;
      result_p1       <= '0;
      rf_we_p1        <= 1'b0;
      rf_waddr_p1     <= '0;
      res_from_mem_p1 <= 1'b0;
      pc_p1           <= '0;
      data_buf_p1     <= '0;
      buf_valid_p1    <= 1'b0;
      discard_cnt     <= '0;
    end else begin
      if (wb_flush)                        vld_p1 <= 1'b0;
      else if (load_in)                    vld_p1 <= 1'b1;
      else if (mem_ready_go & wb_allow_in) vld_p1 <= 1'b0;

      if (load_in & ~wb_flush) begin
        wait_ok_p1      <= ex_wait_data_ok;
        ld_ctrl_p1      <= ex_ld_ctrl;
        result_p1       <= ex_result;
        rf_we_p1        <= ex_rf_we;
        rf_waddr_p1     <= ex_rf_waddr;
        res_from_mem_p1 <= ex_res_from_mem;
        pc_p1           <= ex_pc;
      end

      if (wb_flush | handoff) begin
        buf_valid_p1 <= 1'b0;
      end else if (buf_latch) begin
        buf_valid_p1 <= 1'b1;
        data_buf_p1  <= data_sram_rdata;
      end

      if (discard_inc && discard_cnt != DISCARD_MAX) discard_cnt <= discard_cnt + DISCARD_ONE;
      else if (discard_dec)                          discard_cnt <= discard_cnt - DISCARD_ONE;
    end
  end

  assign ld_raw           = buf_valid_p1 ? data_buf_p1 : data_sram_rdata;
  assign mem_final_result = load_extract(ld_ctrl_p1, result_p1[1:0], ld_raw, result_p1);
  assign mem_to_wb_valid  = vld_p1 & mem_ready_go & ~wb_flush;
  assign mem_rf_we        = rf_we_p1;
  assign mem_rf_waddr     = rf_waddr_p1;
  assign mem_pc           = pc_p1;
  assign mem_bypass_we    = rf_we_p1 & vld_p1;
  assign mem_bypass_waddr = rf_waddr_p1;
  assign mem_bypass_data  = mem_final_result;

`ifdef MEM_LOAD_FWD_EN
  assign mem_bypass_busy = vld_p1 & res_from_mem_p1 & ~mem_ready_go;
`else
  // Dependents wait until the load data sits in data_buf or the load has moved on to WB.
  assign mem_bypass_busy = vld_p1 & res_from_mem_p1 & wait_ok_p1 & ~buf_valid_p1;
`endif

`ifndef SYNTHESIS
  discard_overflow: assert property (@(posedge clk) disable iff (reset)
    !(discard_inc && discard_cnt == DISCARD_MAX));
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized loads against a reference model.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        ex_valid, ex_ready_go, ex_wait_data_ok;
  logic [4:0]  ex_ld_ctrl;
  logic [31:0] ex_result;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic        ex_res_from_mem;
  logic [31:0] ex_pc;
  logic        mem_allow_in;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        wb_allow_in, wb_flush;
  logic        mem_to_wb_valid;
  logic [31:0] mem_final_result;
  logic        mem_rf_we;
  logic [4:0]  mem_rf_waddr;
  logic [31:0] mem_pc;
  logic        mem_bypass_we;
  logic [4:0]  mem_bypass_waddr;
  logic        mem_bypass_busy;
  logic [31:0] mem_bypass_data;

  int checks = 0;
  int errors = 0;

`ifdef MEM_LOAD_FWD_EN
  localparam logic BUSY_ON_OK = 1'b0;
`else
  localparam logic BUSY_ON_OK = 1'b1;
`endif

  localparam logic [4:0] LD_W = 5'b10000, LD_BU = 5'b01000, LD_B = 5'b00100,
                         LD_HU = 5'b00010, LD_H = 5'b00001, NO_LD = 5'b00000;

  mem_stage #(.DISCARD_W(2)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready_go(ex_ready_go), .ex_wait_data_ok(ex_wait_data_ok),
    .ex_ld_ctrl(ex_ld_ctrl), .ex_result(ex_result), .ex_rf_we(ex_rf_we),
    .ex_rf_waddr(ex_rf_waddr), .ex_res_from_mem(ex_res_from_mem), .ex_pc(ex_pc),
    .mem_allow_in(mem_allow_in),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .wb_allow_in(wb_allow_in), .wb_flush(wb_flush),
    .mem_to_wb_valid(mem_to_wb_valid), .mem_final_result(mem_final_result),
    .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr), .mem_pc(mem_pc),
    .mem_bypass_we(mem_bypass_we), .mem_bypass_waddr(mem_bypass_waddr),
    .mem_bypass_busy(mem_bypass_busy), .mem_bypass_data(mem_bypass_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural load semantics with shifts and masks on whole words.
  function automatic logic [31:0] ref_load(input logic [4:0] ld, input logic [31:0] addr,
                                           input logic [31:0] r);
    logic [31:0] sh, v;
    if (ld == LD_W) return r;
    if (ld == LD_B || ld == LD_BU) begin
      sh = (addr % 32'd4) * 32'd8;
      v  = (r >> sh) & 32'h0000_00FF;
      if (ld == LD_B && v >= 32'd128) v = v | 32'hFFFF_FF00;
      return v;
    end
    if (ld == LD_H || ld == LD_HU) begin
      sh = ((addr % 32'd4) / 32'd2) * 32'd16;
      v  = (r >> sh) & 32'h0000_FFFF;
      if (ld == LD_H && v >= 32'd32768) v = v | 32'hFFFF_0000;
      return v;
    end
    return addr;
  endfunction

  task automatic drive_ex(input logic [4:0] ld, input logic [31:0] res, input logic [4:0] wa,
                          input logic [31:0] pc);
    ex_valid        = 1'b1;
    ex_ready_go     = 1'b1;
    ex_wait_data_ok = |ld;
    ex_ld_ctrl      = ld;
    ex_result       = res;
    ex_rf_we        = 1'b1;
    ex_rf_waddr     = wa;
    ex_res_from_mem = |ld;
    ex_pc           = pc;
  endtask

  // One instruction through MEM: dly cycles before data_ok, then WB stalls for stall cycles.
  task automatic run_txn(input logic [4:0] ld, input logic [31:0] res, input logic [31:0] rd,
                         input int dly, input int stall, input logic [31:0] exp);
    logic       is_ld;
    logic [4:0] wa;
    logic [31:0] pc;
    is_ld = |ld;
    wa    = 5'($urandom_range(1, 31));
    pc    = $urandom & 32'hFFFF_FFFC;
    @(negedge clk);
    drive_ex(ld, res, wa, pc);
    data_sram_data_ok = 1'b0;
    wb_allow_in       = 1'b1;
    wb_flush          = 1'b0;
    #1 chk("allow_in_idle", mem_allow_in, 1);
    @(negedge clk);
    ex_valid = 1'b0;
    if (is_ld) begin
      for (int c = 0; c < dly; c++) begin
        data_sram_rdata = $urandom;
        #1;
        chk("wait_to_wb_valid", mem_to_wb_valid, 0);
        chk("wait_busy", mem_bypass_busy, 1);
        @(negedge clk);
      end
    end
    data_sram_data_ok = is_ld;
    data_sram_rdata   = rd;
    wb_allow_in       = (stall == 0);
    #1;
    chk("to_wb_valid", mem_to_wb_valid, 1);
    chk("final_result", mem_final_result, exp);
    chk("bypass_data", mem_bypass_data, exp);
    chk("bypass_busy", mem_bypass_busy, is_ld ? BUSY_ON_OK : 1'b0);
    chk("bypass_we", mem_bypass_we, 1);
    chk("rf_waddr", mem_rf_waddr, wa);
    chk("pc", mem_pc, pc);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = ~rd;
      wb_allow_in       = (s == stall - 1);
      #1;
      chk("stall_to_wb_valid", mem_to_wb_valid, 1);
      chk("stall_result", mem_final_result, exp);
      chk("stall_busy", mem_bypass_busy, 0);
    end
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    wb_allow_in       = 1'b1;
    #1;
    chk("left_to_wb_valid", mem_to_wb_valid, 0);
    chk("left_allow_in", mem_allow_in, 1);
  endtask

  // Issue a waiting ld_w, then flush it before any response so one response is owed.
  task automatic flush_waiting_load();
    @(negedge clk);
    drive_ex(LD_W, 32'h0000_2000, 5'd3, 32'h1C00_0000);
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0;
    wb_flush = 1'b1;
    #1 chk("flush_to_wb_valid", mem_to_wb_valid, 0);
    @(negedge clk);
    wb_flush = 1'b0;
  endtask

  initial begin
    logic [4:0]  ld;
    logic [31:0] a, rd;
    int          k;

    reset = 1'b1;
    ex_valid = 1'b0; ex_ready_go = 1'b0; ex_wait_data_ok = 1'b0; ex_ld_ctrl = '0;
    ex_result = '0; ex_rf_we = 1'b0; ex_rf_waddr = '0; ex_res_from_mem = 1'b0; ex_pc = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; wb_allow_in = 1'b1; wb_flush = 1'b0;
    #1;
    chk("rst_to_wb_valid", mem_to_wb_valid, 0);
    chk("rst_allow_in", mem_allow_in, 1);
    chk("rst_result", mem_final_result, 0);
    chk("rst_busy", mem_bypass_busy, 0);
    chk("rst_bypass_we", mem_bypass_we, 0);
    chk("rst_rf_we", mem_rf_we, 0);
    chk("rst_pc", mem_pc, 0);
    @(negedge clk);
    reset = 1'b0;

    run_txn(LD_B,  32'h0000_1003, 32'h80FF_1234, 0, 0, 32'hFFFF_FF80);
    run_txn(LD_BU, 32'h0000_1003, 32'h80FF_1234, 0, 0, 32'h0000_0080);
    run_txn(LD_H,  32'h0000_1002, 32'h8001_7FFF, 0, 0, 32'hFFFF_8001);
    run_txn(LD_HU, 32'h0000_1002, 32'h8001_7FFF, 0, 0, 32'h0000_8001);
    run_txn(LD_W,  32'h0000_1000, 32'h8001_7FFF, 0, 0, 32'h8001_7FFF);
    run_txn(LD_W,  32'h0000_1000, 32'hDEAD_BEEF, 0, 3, 32'hDEAD_BEEF);
    run_txn(NO_LD, 32'h0000_0042, 32'h0000_0000, 0, 0, 32'h0000_0042);

    // Stale response after a flush is dropped; the next one completes the new load.
    flush_waiting_load();
    drive_ex(LD_W, 32'h0000_3000, 5'd4, 32'h1C00_0010);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_1111;
    #1;
    chk("discard_allow_in", mem_allow_in, 0);
    chk("discard_to_wb_valid", mem_to_wb_valid, 0);
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    #1 chk("drained_allow_in", mem_allow_in, 1);
    @(negedge clk);
    ex_valid          = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h2222_2222;
    #1;
    chk("post_discard_to_wb_valid", mem_to_wb_valid, 1);
    chk("post_discard_result", mem_final_result, 32'h2222_2222);
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    #1 chk("post_discard_left", mem_to_wb_valid, 0);

    // Reset in the middle of a wait clears the stage without a clock edge.
    @(negedge clk);
    drive_ex(LD_W, 32'h0000_4000, 5'd5, 32'h1C00_0020);
    @(negedge clk);
    ex_valid          = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h3333_3333;
    #1 chk("pre_reset_to_wb_valid", mem_to_wb_valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_to_wb_valid", mem_to_wb_valid, 0);
    chk("async_rst_allow_in", mem_allow_in, 1);
    chk("async_rst_busy", mem_bypass_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    data_sram_data_ok = 1'b0;

    // Reset also clears a pending discard count.
    flush_waiting_load();
    drive_ex(LD_W, 32'h0000_5000, 5'd6, 32'h1C00_0030);
    #1 chk("cnt_pending_allow_in", mem_allow_in, 0);
    #1 reset = 1'b1;
    #1 chk("cnt_rst_allow_in", mem_allow_in, 1);
    @(negedge clk);
    reset    = 1'b0;
    ex_valid = 1'b0;
    run_txn(LD_H, 32'h0000_6000, 32'h1234_F00D, 1, 1, 32'hFFFF_F00D);

    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 5);
      case (k)
        0:       ld = LD_W;
        1:       ld = LD_BU;
        2:       ld = LD_B;
        3:       ld = LD_HU;
        4:       ld = LD_H;
        default: ld = NO_LD;
      endcase
      a  = $urandom;
      if (ld == LD_W) a = a & 32'hFFFF_FFFC;
      if (ld == LD_H || ld == LD_HU) a = a & 32'hFFFF_FFFE;
      rd = $urandom;
      run_txn(ld, a, rd, $urandom_range(0, 3), $urandom_range(0, 3), ref_load(ld, a, rd));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
